bpu_resolver: RTL and testbench

//  EX-side counterpart of the branch predictor. Queues each IF-stage prediction in order,

---
 rtl/bpu_resolver.sv | 156 +++++++++++++++
 tb/tb_bpu_resolver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_resolver.sv
// EX-side branch resolver: in-order prediction queue, mispredict flush/redirect, training bus.
// Optional BPU_PERF_CNT_EN adds saturating resolve/mispredict counters.
module bpu_resolver #(
    parameter int DEPTH     = 4,
    parameter int DRAIN_CYC = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pred_valid_IF,
    input  logic [31:0] pc_IF,
    input  logic        pred_taken_IF,
    input  logic [31:0] pred_target_IF,
    input  logic        resolve_EX,
    input  logic [31:0] pc_EX,
    input  logic        pc_sel_EX,
    input  logic [31:0] aludata_EX,
    output logic        q_full_o,
    output logic        flush_br,
    output logic [31:0] redirect_pc,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic        upd_taken,
    output logic [31:0] upd_target,
    output logic        upd_mispred
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0] perf_br_o,
    output logic [31:0] perf_mis_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DRAIN_CYC + 1);
    localparam logic [CW-1:0] CLAST = CW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, wr_q;

    logic [31:0] q_pc  [DEPTH];
    logic [31:0] q_tgt [DEPTH];
    logic        q_tk  [DEPTH];

    logic        run, empty, full, head_hit;
    logic        res_ok, mispred, mis_ev, pop, push;
    logic        p_taken;
    logic [31:0] p_tgt, pc_inc, act_tgt;

    always_comb begin
        run      = (state_q == RUN);
        empty    = (rd_q == wr_q);
        full     = (rd_q[PW-1] != wr_q[PW-1]) &&
                   (rd_q[AW-1:0] == wr_q[AW-1:0]);
        head_hit = !empty && (q_pc[rd_q[AW-1:0]] == pc_EX);
        pc_inc   = pc_EX + 32'd4;
        // A missing or mismatched head is resolved as a not-taken guess.
        p_taken  = head_hit && q_tk[rd_q[AW-1:0]];
        p_tgt    = head_hit ? q_tgt[rd_q[AW-1:0]] : pc_inc;
        act_tgt  = pc_sel_EX ? aludata_EX : pc_inc;
        res_ok   = resolve_EX && run;
        mispred  = (pc_sel_EX != p_taken) ||
                   (pc_sel_EX && p_taken && (aludata_EX != p_tgt));
        mis_ev   = res_ok && mispred;
        pop      = res_ok && head_hit;
        push     = pred_valid_IF && run && !mis_ev && (!full || pop);
    end

    assign q_full_o = full;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            RUN:   if (mis_ev) state_d = FLUSH;
            FLUSH: state_d = DRAIN;
            DRAIN: begin
                if (cnt_q == CLAST) state_d = RUN;
                else                cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= '0;
            wr_q <= '0;
        end else if (state_q == FLUSH) begin
            rd_q <= '0;
            wr_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_pc[wr_q[AW-1:0]]  <= pc_IF;
            q_tk[wr_q[AW-1:0]]  <= pred_taken_IF;
            q_tgt[wr_q[AW-1:0]] <= pred_target_IF;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_br    <= 1'b0;
            redirect_pc <= '0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            upd_target  <= '0;
            upd_mispred <= 1'b0;
        end else begin
            flush_br  <= mis_ev;
            upd_valid <= res_ok;
            if (mis_ev) redirect_pc <= act_tgt;
            if (res_ok) begin
                upd_pc      <= pc_EX;
                upd_taken   <= pc_sel_EX;
                upd_target  <= act_tgt;
                upd_mispred <= mispred;
            end
        end
    end

`ifdef BPU_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_br_o  <= '0;
            perf_mis_o <= '0;
        end else begin
            if (res_ok && perf_br_o != '1)  perf_br_o  <= perf_br_o + 32'd1;
            if (mis_ev && perf_mis_o != '1) perf_mis_o <= perf_mis_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bpu_resolver.sv
// Scoreboard bench for bpu_resolver: expected training/flush results queued at resolve time.
// Counter checks are compiled in when BPU_PERF_CNT_EN is defined.
module tb_bpu_resolver;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        pred_valid_IF = 1'b0;
    logic [31:0] pc_IF = '0;
    logic        pred_taken_IF = 1'b0;
    logic [31:0] pred_target_IF = '0;
    logic        resolve_EX = 1'b0;
    logic [31:0] pc_EX = '0;
    logic        pc_sel_EX = 1'b0;
    logic [31:0] aludata_EX = '0;
    logic        q_full_o, flush_br, upd_valid, upd_taken, upd_mispred;
    logic [31:0] redirect_pc, upd_pc, upd_target;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_br_o, perf_mis_o;
`endif

    bpu_resolver dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pred_valid_IF  (pred_valid_IF),
        .pc_IF          (pc_IF),
        .pred_taken_IF  (pred_taken_IF),
        .pred_target_IF (pred_target_IF),
        .resolve_EX     (resolve_EX),
        .pc_EX          (pc_EX),
        .pc_sel_EX      (pc_sel_EX),
        .aludata_EX     (aludata_EX),
        .q_full_o       (q_full_o),
        .flush_br       (flush_br),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispred    (upd_mispred)
`ifdef BPU_PERF_CNT_EN
        ,
        .perf_br_o      (perf_br_o),
        .perf_mis_o     (perf_mis_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic drive(input logic pv, input logic [31:0] ppc,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic rv, input logic [31:0] rpc,
                         input logic rsel, input logic [31:0] ralu,
                         input logic ex, input logic emis);
        exp_t x;
        pred_valid_IF  = pv;
        pc_IF          = ppc;
        pred_taken_IF  = ptk;
        pred_target_IF = ptgt;
        resolve_EX     = rv;
        pc_EX          = rpc;
        pc_sel_EX      = rsel;
        aludata_EX     = ralu;
        if (rv && ex) begin
            x.pc  = rpc;
            x.tk  = rsel;
            x.tgt = rsel ? ralu : rpc + 32'd4;
            x.mis = emis;
            sb.push_back(x);
        end
        @(posedge clk_i);
        #1;
        pred_valid_IF = 1'b0;
        resolve_EX    = 1'b0;
        pc_IF         = '0;
        pc_EX         = '0;
        pc_sel_EX     = 1'b0;
        aludata_EX    = '0;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt);
        drive(1'b1, pc, tk, tgt, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic res(input logic [31:0] pc, input logic sel,
                       input logic [31:0] alu, input logic mis);
        drive(1'b0, '0, 1'b0, '0, 1'b1, pc, sel, alu, 1'b1, mis);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (upd_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_upd", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("upd_pc", upd_pc, e.pc);
                    chk("upd_taken", {31'd0, upd_taken}, {31'd0, e.tk});
                    chk("upd_target", upd_target, e.tgt);
                    chk("upd_mispred", {31'd0, upd_mispred}, {31'd0, e.mis});
                    chk("flush_br", {31'd0, flush_br}, {31'd0, e.mis});
                    if (e.mis) chk("redirect_pc", redirect_pc, e.tgt);
                end
            end else if (flush_br) begin
                chk("stray_flush", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        #3;
        chk("rst_flush", {31'd0, flush_br}, 32'd0);
        chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("rst_full", {31'd0, q_full_o}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_upd_pc", upd_pc, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(1);

        // correct taken prediction
        push(32'h100, 1'b1, 32'h200);
        res(32'h100, 1'b1, 32'h200, 1'b0);
        idle(1);
        // predicted not-taken, actually taken
        push(32'h104, 1'b0, 32'h0);
        res(32'h104, 1'b1, 32'h40, 1'b1);
        idle(3);
        // predicted taken, actually not-taken
        push(32'h108, 1'b1, 32'h300);
        res(32'h108, 1'b0, 32'h0, 1'b1);
        idle(3);
`ifdef BPU_PERF_CNT_EN
        chk("perf_br", perf_br_o, 32'd3);
        chk("perf_mis", perf_mis_o, 32'd2);
`endif
        // queue emptied by the flush: same PC again is a not-taken guess
        res(32'h108, 1'b1, 32'h300, 1'b1);
        idle(3);

        // fill, drop, pop+push, in-order retire
        push(32'h200, 1'b1, 32'h300);
        push(32'h204, 1'b1, 32'h304);
        push(32'h208, 1'b1, 32'h308);
        chk("full_at3", {31'd0, q_full_o}, 32'd0);
        push(32'h20C, 1'b1, 32'h30C);
        chk("full_at4", {31'd0, q_full_o}, 32'd1);
        push(32'h210, 1'b1, 32'h310);
        chk("full_drop", {31'd0, q_full_o}, 32'd1);
        drive(1'b1, 32'h214, 1'b1, 32'h314,
              1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 1'b0);
        chk("full_pushpop", {31'd0, q_full_o}, 32'd1);
        res(32'h204, 1'b1, 32'h304, 1'b0);
        chk("full_after_pop", {31'd0, q_full_o}, 32'd0);
        res(32'h208, 1'b1, 32'h308, 1'b0);
        res(32'h20C, 1'b1, 32'h30C, 1'b0);
        res(32'h214, 1'b1, 32'h314, 1'b0);
        res(32'h210, 1'b1, 32'h310, 1'b1);
        idle(3);

        // wrong target, then inputs during FLUSH/DRAIN must be ignored
        push(32'h500, 1'b1, 32'h600);
        res(32'h500, 1'b1, 32'h604, 1'b1);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h400, 1'b1, 32'h500,
                  1'b1, 32'h700, 1'b1, 32'h800, 1'b0, 1'b0);
        res(32'h400, 1'b0, 32'h0, 1'b0);
        idle(1);

        // pc+4 wrap with empty queue
        res(32'hFFFF_FFFC, 1'b1, 32'h1234, 1'b1);
        idle(3);
        res(32'hFFFF_FFFC, 1'b0, 32'h5555, 1'b0);
        idle(1);

        // reset during DRAIN
        res(32'h800, 1'b1, 32'h900, 1'b1);
        idle(1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("drain_rst_flush", {31'd0, flush_br}, 32'd0);
        chk("drain_rst_upd", {31'd0, upd_valid}, 32'd0);
        chk("drain_rst_redirect", redirect_pc, 32'd0);
        chk("drain_rst_full", {31'd0, q_full_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        push(32'hA00, 1'b1, 32'hB00);
        res(32'hA00, 1'b1, 32'hB00, 1'b0);
        idle(1);

        // flush_br drops asynchronously on reset
        drive(1'b0, '0, 1'b0, '0, 1'b1, 32'hC00, 1'b1, 32'hD00, 1'b0, 1'b0);
        #1;
        chk("flush_pulse", {31'd0, flush_br}, 32'd1);
        chk("flush_redirect", redirect_pc, 32'hD00);
        rst_ni = 1'b0;
        #1;
        chk("flush_async_rst", {31'd0, flush_br}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(3);

        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
